// File: rtl/bidir_pio_pkg.sv
// Shared definitions for the bidirectional PIO with edge-capture interrupt:
// register offsets, edge-select encodings and the synchroniser depth check.
package bidir_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic bit sync_stages_legal(input int stages);
    return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/pio_sync_chain.sv
// WIDTH-wide, STAGES-deep flop chain bringing asynchronous pin levels into
// the clk domain; every stage clears on reset.
module pio_sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/bidir_pio_irq.sv
// N-bit bidirectional PIO Avalon-MM slave with per-bit direction, atomic
// set/clear of outputs, synchronised inputs and maskable edge-capture irq.
module bidir_pio_irq
  import bidir_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int OPEN_DRAIN  = 0,
  parameter int RESET_OUT   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  generate
    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync
      $error("bidir_pio_irq: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  localparam logic [WIDTH-1:0] DATA_OUT_RST = (RESET_OUT != 0) ? '1 : '0;
  localparam logic [2:0]       ARM_CYCLES   = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] read_mux;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             wr;

  assign wr = chipselect && !write_n;

  // Pin drivers: push-pull follows data_out, open-drain only ever pulls low.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      if (OPEN_DRAIN != 0) begin : g_od
        assign bidir_port[i] = (dir[i] && !data_out[i]) ? 1'b0 : 1'bz;
      end else begin : g_pp
        assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
      end
    end
  endgenerate

  pio_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bidir_port),
    .q       (sync_in)
  );

  // The chain and prev both reset to 0, so a pin held high through reset
  // would look like a rising edge until the chain has filled and prev has
  // caught up; the arm counter hides that window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_CYCLES) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign armed = (arm_cnt == ARM_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= sync_in;
    end
  end

  assign rise = sync_in & ~prev;
  assign fall = ~sync_in & prev;

  always_comb begin
    edge_evt = rise;
    case (EDGE_TYPE)
      EDGE_FALL: edge_evt = fall;
      EDGE_ANY:  edge_evt = rise | fall;
      default:   edge_evt = rise;
    endcase
    if (!armed) begin
      edge_evt = '0;
    end
  end

  always_comb begin
    cap_clr = '0;
    if (wr && (address == ADDR_EDGECAP)) begin
      cap_clr = writedata;
    end
  end

  // A new edge in the same cycle as a write-1-to-clear keeps its bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= DATA_OUT_RST;
      dir      <= '0;
      irq_mask <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:    data_out <= writedata;
        ADDR_DIR:     dir      <= writedata;
        ADDR_IRQMASK: irq_mask <= writedata;
        ADDR_OUTSET:  data_out <= data_out | writedata;
        ADDR_OUTCLR:  data_out <= data_out & ~writedata;
        default:      ;
      endcase
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:    read_mux = sync_in;
      ADDR_DIR:     read_mux = dir;
      ADDR_IRQMASK: read_mux = irq_mask;
      ADDR_EDGECAP: read_mux = edge_cap;
      default:      read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_bidir_pio_irq.sv
// Directed bench for bidir_pio_irq: one push-pull instance and one
// open-drain instance sharing clock, reset and bus lines.
module tb_bidir_pio_irq;

  localparam int W = 8;
  localparam int S = 2;

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;
  localparam logic [2:0] A_UNUSED  = 3'd6;

  logic         clk;
  logic         reset_n;
  logic [2:0]   address;
  logic         cs;
  logic         cs_od;
  logic         write_n;
  logic [W-1:0] writedata;
  logic [W-1:0] readdata;
  logic [W-1:0] readdata_od;
  logic         irq;
  logic         irq_od;
  wire  [W-1:0] pins;
  wire  [W-1:0] pins_od;

  logic [W-1:0] ext_en;
  logic [W-1:0] ext_val;
  logic [W-1:0] ext_od_en;
  logic [W-1:0] ext_od_val;

  int n_checks;
  int n_fail;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pin drivers standing in for the board
  generate
    for (genvar i = 0; i < W; i++) begin : g_ext
      assign pins[i]    = ext_en[i]    ? ext_val[i]    : 1'bz;
      assign pins_od[i] = ext_od_en[i] ? ext_od_val[i] : 1'bz;
    end
  endgenerate

  bidir_pio_irq #(
    .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .OPEN_DRAIN(0), .RESET_OUT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .bidir_port(pins)
  );

  bidir_pio_irq #(
    .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .OPEN_DRAIN(1), .RESET_OUT(0)
  ) dut_od (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_od),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_od),
    .irq(irq_od), .bidir_port(pins_od)
  );

  // Driver tasks: inputs change on the falling edge, outputs are sampled there too.
  task automatic bus_write(input logic [2:0] a, input logic [W-1:0] d, input bit od);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0;
    cs = !od; cs_od = od;
    @(negedge clk);
    write_n = 1'b1; cs = 1'b0; cs_od = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input bit od, output logic [W-1:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = od ? readdata_od : readdata;
  endtask

  task automatic test_reset();
    logic [W-1:0] rd;
    ext_en = 8'hFF; ext_val = 8'h5A;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (readdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_readdata: got %h expected 00", readdata);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pins !== 8'h5A) begin
      n_fail++; $display("FAIL reset_pins_released: got %h expected 5a", pins);
    end
    bus_read(A_DIR, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL reset_dir: got %h expected 00", rd);
    end
    bus_read(A_IRQMASK, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL reset_irqmask: got %h expected 00", rd);
    end
    repeat (6) @(negedge clk);
    bus_read(A_EDGECAP, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL reset_edgecap_no_spurious: got %h expected 00", rd);
    end
    bus_read(A_DATA, 0, rd);
    n_checks++;
    if (rd !== 8'h5A) begin
      n_fail++; $display("FAIL reset_data_in: got %h expected 5a", rd);
    end
    ext_en = 8'h00;
  endtask

  task automatic test_drive_dir();
    logic [W-1:0] rd;
    bus_write(A_DIR, 8'h0F, 0);
    bus_write(A_DATA, 8'hA5, 0);
    ext_en = 8'hF0; ext_val = 8'h30;
    @(negedge clk);
    n_checks++;
    if (pins[3:0] !== 4'h5) begin
      n_fail++; $display("FAIL drive_low_nibble: got %h expected 5", pins[3:0]);
    end
    n_checks++;
    if (pins !== 8'h35) begin
      n_fail++; $display("FAIL drive_upper_released: got %h expected 35", pins);
    end
    repeat (S + 1) @(negedge clk);
    bus_read(A_DATA, 0, rd);
    n_checks++;
    if (rd !== 8'h35) begin
      n_fail++; $display("FAIL drive_data_read: got %h expected 35", rd);
    end
    bus_read(A_DIR, 0, rd);
    n_checks++;
    if (rd !== 8'h0F) begin
      n_fail++; $display("FAIL drive_dir_read: got %h expected 0f", rd);
    end
    ext_en = 8'h00;
  endtask

  task automatic test_set_clear();
    logic [W-1:0] rd;
    bus_write(A_DIR, 8'hFF, 0);
    bus_write(A_OUTSET, 8'h0A, 0);
    n_checks++;
    if (pins !== 8'hAF) begin
      n_fail++; $display("FAIL outset: got %h expected af", pins);
    end
    bus_write(A_OUTCLR, 8'h81, 0);
    n_checks++;
    if (pins !== 8'h2E) begin
      n_fail++; $display("FAIL outclr: got %h expected 2e", pins);
    end
    repeat (S + 1) @(negedge clk);
    bus_read(A_DATA, 0, rd);
    n_checks++;
    if (rd !== 8'h2E) begin
      n_fail++; $display("FAIL setclr_data_read: got %h expected 2e", rd);
    end
    bus_read(A_OUTSET, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL outset_read: got %h expected 00", rd);
    end
    bus_read(A_OUTCLR, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL outclr_read: got %h expected 00", rd);
    end
    bus_write(A_UNUSED, 8'hFF, 0);
    bus_read(A_UNUSED, 0, rd);
    n_checks++;
    if (rd !== 8'h00 || pins !== 8'h2E) begin
      n_fail++; $display("FAIL unused_offset: got rd=%h pins=%h expected rd=00 pins=2e", rd, pins);
    end
    bus_read(A_DIR, 0, rd);
    n_checks++;
    if (rd !== 8'hFF) begin
      n_fail++; $display("FAIL unused_write_ignored_dir: got %h expected ff", rd);
    end
    bus_write(A_DIR, 8'h00, 0);
  endtask

  task automatic test_edge_irq();
    logic [W-1:0] rd;
    ext_en = 8'hFF; ext_val = 8'h00;
    repeat (S + 3) @(negedge clk);
    bus_write(A_EDGECAP, 8'hFF, 0);
    bus_write(A_IRQMASK, 8'h01, 0);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL edge_irq_idle: got %b expected 0", irq);
    end
    @(negedge clk);
    ext_val[0] = 1'b1;
    repeat (S) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL edge_irq_early: got %b expected 0", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL edge_irq_latency: got %b expected 1", irq);
    end
    bus_read(A_EDGECAP, 0, rd);
    n_checks++;
    if (rd !== 8'h01) begin
      n_fail++; $display("FAIL edge_cap_rise: got %h expected 01", rd);
    end
    bus_write(A_EDGECAP, 8'h01, 0);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL edge_irq_clear: got %b expected 0", irq);
    end
    ext_val[0] = 1'b0;
    repeat (S + 3) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL edge_fall_irq: got %b expected 0", irq);
    end
    bus_read(A_EDGECAP, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL edge_fall_ignored: got %h expected 00", rd);
    end
  endtask

  task automatic test_set_beats_clear();
    logic [W-1:0] rd;
    ext_val[0] = 1'b1;
    repeat (S + 2) @(negedge clk);
    @(negedge clk);
    ext_val[2] = 1'b1;
    repeat (S) @(negedge clk);
    // The capture of bit 2 and this clear land on the same rising edge.
    address = A_EDGECAP; writedata = 8'h05; write_n = 1'b0; cs = 1'b1;
    @(negedge clk);
    write_n = 1'b1; cs = 1'b0;
    bus_read(A_EDGECAP, 0, rd);
    n_checks++;
    if (rd !== 8'h04) begin
      n_fail++; $display("FAIL set_beats_clear: got %h expected 04", rd);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL masked_irq: got %b expected 0", irq);
    end
    bus_write(A_IRQMASK, 8'h04, 0);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL mask_enable_irq: got %b expected 1", irq);
    end
    bus_write(A_EDGECAP, 8'hFF, 0);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL clear_all_irq: got %b expected 0", irq);
    end
    bus_read(A_EDGECAP, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL clear_all_edgecap: got %h expected 00", rd);
    end
  endtask

  task automatic test_reset_arming();
    logic [W-1:0] rd;
    @(negedge clk);
    ext_val = 8'h02;
    repeat (S + 3) @(negedge clk);
    bus_write(A_IRQMASK, 8'h02, 0);
    // Reset drops in the middle of a DIR write.
    @(negedge clk);
    address = A_DIR; writedata = 8'hF0; write_n = 1'b0; cs = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1; cs = 1'b0;
    n_checks++;
    if (readdata !== 8'h00 || irq !== 1'b0) begin
      n_fail++; $display("FAIL arm_in_reset: got rd=%h irq=%b expected 00/0", readdata, irq);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (S + 6) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL arm_irq_after_release: got %b expected 0", irq);
    end
    bus_read(A_EDGECAP, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL arm_no_spurious_edge: got %h expected 00", rd);
    end
    bus_read(A_IRQMASK, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL arm_irqmask_reset: got %h expected 00", rd);
    end
    bus_read(A_DIR, 0, rd);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL arm_dir_reset: got %h expected 00", rd);
    end
    bus_write(A_IRQMASK, 8'h02, 0);
    ext_val[1] = 1'b0;
    repeat (S + 3) @(negedge clk);
    ext_val[1] = 1'b1;
    repeat (S + 2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL arm_genuine_irq: got %b expected 1", irq);
    end
    bus_read(A_EDGECAP, 0, rd);
    n_checks++;
    if (rd !== 8'h02) begin
      n_fail++; $display("FAIL arm_genuine_edge: got %h expected 02", rd);
    end
    ext_en = 8'h00;
  endtask

  task automatic test_open_drain();
    logic [W-1:0] rd;
    ext_od_en = 8'h00;
    bus_write(A_DIR, 8'hFF, 1);
    bus_write(A_DATA, 8'hF0, 1);
    n_checks++;
    if (pins_od[3:0] !== 4'h0) begin
      n_fail++; $display("FAIL od_low_nibble: got %h expected 0", pins_od[3:0]);
    end
    ext_od_en = 8'hF0; ext_od_val = 8'hF0;
    @(negedge clk);
    n_checks++;
    if (pins_od !== 8'hF0) begin
      n_fail++; $display("FAIL od_pullup: got %h expected f0", pins_od);
    end
    repeat (S + 1) @(negedge clk);
    bus_read(A_DATA, 1, rd);
    n_checks++;
    if (rd !== 8'hF0) begin
      n_fail++; $display("FAIL od_data_read: got %h expected f0", rd);
    end
    ext_od_val = 8'h50;
    @(negedge clk);
    n_checks++;
    if (pins_od !== 8'h50) begin
      n_fail++; $display("FAIL od_upper_released: got %h expected 50", pins_od);
    end
    bus_write(A_DIR, 8'h00, 1);
    ext_od_en = 8'hFF; ext_od_val = 8'hA5;
    @(negedge clk);
    n_checks++;
    if (pins_od !== 8'hA5) begin
      n_fail++; $display("FAIL od_all_released: got %h expected a5", pins_od);
    end
    repeat (S + 1) @(negedge clk);
    bus_read(A_DATA, 1, rd);
    n_checks++;
    if (rd !== 8'hA5) begin
      n_fail++; $display("FAIL od_all_released_read: got %h expected a5", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; address = '0; cs = 1'b0; cs_od = 1'b0;
    write_n = 1'b1; writedata = '0;
    ext_en = '0; ext_val = '0; ext_od_en = '0; ext_od_val = '0;
    test_reset();
    test_drive_dir();
    test_set_clear();
    test_edge_irq();
    test_set_beats_clear();
    test_reset_arming();
    test_open_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
